phase_sequencer: RTL

Run-control and phase sequencer for the 5-phase multi-cycle core (IF, ID, EX, MEM, WB). It steps the phase counter one phase per clock and drives the one-hot phase enables consumed by the datapath. It handles run, stop and single-step from the front-panel exec/step buttons, and stalls IF/MEM while memory is busy. It stops cleanly on a halt instruction and counts retired instructions. It sits between the board I/O and the datapath, replacing free-running phase generation.

---
 rtl/core_pkg.sv | 23 ++
 rtl/rise_detect.sv | 24 ++
 rtl/phase_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-phase multi-cycle core.
// Holds the phase index constants, the phase count and index width, and the
// run-state encoding. The datapath phase decode reuses the same constants, so
// the sequencer and the datapath always agree on phase numbering.
package core_pkg;

  localparam int CORE_NUM_PHASES = 5;
  localparam int CORE_PHASE_W    = 3;

  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EX  = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } run_state_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit registered rising-edge detector.
// Ports:
//   clock - system clock
//   reset - synchronous, active-high; clears the history flop
//   sig   - level input (already debounced)
//   rise  - high for the one cycle in which sig is high and was low last cycle
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sigQ;

  // History flop keeps last cycle's level so a held button gives one event.
  always_ff @(posedge clock) begin
    if (reset) sigQ <= 1'b0;
    else       sigQ <= sig;
  end

  assign rise = sig & ~sigQ;

endmodule

// File: rtl/phase_sequencer.sv
// Run-control and phase sequencer for the 5-phase multi-cycle core.
// Steps the phase counter one phase per clock, drives the one-hot phase
// enables, handles run/stop and single-step from the front-panel buttons,
// stalls IF/MEM while memory is busy, stops on a halt instruction and counts
// retired instructions.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   exec, step    - run/stop and single-step buttons (level, rising edge used)
//   halt_req      - decoder flags a halt instruction
//   mem_wait      - memory not ready, honoured only in FETCH_PHASE/MEM_PHASE
//   phase         - current phase index
//   phase_bus     - one-hot phase while active, zero otherwise
//   phase_en      - current phase completes this cycle (datapath latch strobe)
//   running       - in RUN or STEP
//   halted        - in HALTED
//   instr_count   - retired instruction count (wraps)
module phase_sequencer
  import core_pkg::*;
#(
  parameter int NUM_PHASES  = CORE_NUM_PHASES,
  parameter int PHASE_W     = CORE_PHASE_W,
  parameter int FETCH_PHASE = PH_IF,
  parameter int MEM_PHASE   = PH_MEM,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  mem_wait,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_bus,
  output logic                  phase_en,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [PHASE_W-1:0] LAST_PH  = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] FETCH_PH = PHASE_W'(FETCH_PHASE);
  localparam logic [PHASE_W-1:0] MEM_PH   = PHASE_W'(MEM_PHASE);

  run_state_t state;
  logic       execRise;
  logic       stepRise;
  logic       haltPend;
  logic       stopPend;
  logic       active;
  logic       stall;
  logic       haltNext;
  logic       stopNext;

  rise_detect execDetect (
    .clock (clock),
    .reset (reset),
    .sig   (exec),
    .rise  (execRise)
  );

  rise_detect stepDetect (
    .clock (clock),
    .reset (reset),
    .sig   (step),
    .rise  (stepRise)
  );

  assign active   = (state == RUN) || (state == STEP);
  assign stall    = active && mem_wait && ((phase == FETCH_PH) || (phase == MEM_PH));
  assign phase_en = active && !stall;
  assign running  = active;
  assign halted   = (state == HALTED);

  // Pending flags including this cycle's request, so a halt or stop seen in
  // the retire cycle itself still takes effect at that retire. Buttons are
  // ignored while single-stepping.
  assign haltNext = haltPend || halt_req;
  assign stopNext = stopPend || ((state == RUN) && execRise);

  // One-hot phase decode, gated to zero whenever the core is not stepping.
  always_comb begin
    phase_bus = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      phase_bus[i] = active && (phase == PHASE_W'(i));
    end
  end

  // Run-control FSM. Halt and stop are only acted on at the WB retire so an
  // instruction is never cut short; the pending flags carry the request until
  // then and are cleared whenever the core leaves RUN/STEP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      instr_count <= '0;
      haltPend    <= 1'b0;
      stopPend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase    <= '0;
          haltPend <= 1'b0;
          stopPend <= 1'b0;
          if (execRise)      state <= RUN;
          else if (stepRise) state <= STEP;
        end
        RUN, STEP: begin
          haltPend <= haltNext;
          stopPend <= stopNext;
          if (phase_en) begin
            if (phase == LAST_PH) begin
              phase       <= '0;
              instr_count <= instr_count + CNT_W'(1);
              if (haltNext) begin
                state    <= HALTED;
                haltPend <= 1'b0;
                stopPend <= 1'b0;
              end else if ((state == STEP) || stopNext) begin
                state    <= IDLE;
                haltPend <= 1'b0;
                stopPend <= 1'b0;
              end
            end else begin
              phase <= phase + PHASE_W'(1);
            end
          end
        end
        HALTED: begin
          phase    <= '0;
          haltPend <= 1'b0;
          stopPend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
